// File: rtl/vector_writeback_if.sv
// Execution-result handshake into the vector writeback stage.
// master = SIMD execution stage, slave = writeback stage.
interface vector_writeback_if #(
    parameter int BITS_ARRAY = 64,
    parameter int BITS_ADDR  = 3,
    parameter int LANES      = 8
);
    logic                  valid;
    logic                  ready;
    logic [BITS_ADDR-1:0]  dest;
    logic [LANES-1:0]      mask;
    logic [BITS_ARRAY-1:0] result;

    modport master (
        output valid,
        output dest,
        output mask,
        output result,
        input  ready
    );

    modport slave (
        input  valid,
        input  dest,
        input  mask,
        input  result,
        output ready
    );
endinterface

// File: rtl/vector_writeback.sv
// Vector writeback stage: 2-entry result FIFO, load-priority write port,
// 8 x 64-bit register file with lane masks and bypassed read ports.
module vector_writeback #(
    parameter int BITS_ARRAY = 64,
    parameter int BITS_DATA  = 8,
    parameter int REG_COUNT  = 8,
    parameter int BITS_ADDR  = 3,
    parameter int BITS_CNT   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    vector_writeback_if.slave     ex,
    input  logic                  ld_valid,
    input  logic [BITS_ADDR-1:0]  ld_dest,
    input  logic [BITS_ARRAY-1:0] ld_data,
    input  logic [BITS_ADDR-1:0]  rd_addr_a,
    output logic [BITS_ARRAY-1:0] rd_data_a,
    input  logic [BITS_ADDR-1:0]  rd_addr_b,
    output logic [BITS_ARRAY-1:0] rd_data_b,
    output logic [REG_COUNT-1:0]  busy_mask,
    output logic [BITS_CNT-1:0]   wb_count
);
    localparam int LANES = BITS_ARRAY / BITS_DATA;

    typedef struct packed {
        logic [BITS_ADDR-1:0]  dest;
        logic [LANES-1:0]      mask;
        logic [BITS_ARRAY-1:0] data;
    } entry_t;

    entry_t                fifo [2];
    logic [1:0]            vld;
    logic [1:0]            vld_nxt;
    logic                  wp;
    logic                  rp;
    logic [BITS_ARRAY-1:0] regs [REG_COUNT];

    logic                  push;
    logic                  pop;
    logic                  ld_we;
    entry_t                head;
    logic                  wr_en;
    logic [BITS_ADDR-1:0]  wr_addr;
    logic [LANES-1:0]      wr_lanes;
    logic [BITS_ARRAY-1:0] wr_data;

    // ready depends only on registered occupancy (and reset), never on pop
    assign ex.ready = ~rst & ~(&vld);

    always_comb begin
        push     = ex.valid & ex.ready;
        ld_we    = ~rst & ld_valid;
        pop      = ~rst & ~ld_valid & (|vld);
        head     = fifo[rp];
        wr_en    = ld_we | pop;
        wr_addr  = ld_we ? ld_dest : head.dest;
        wr_lanes = ld_we ? {LANES{1'b1}} : head.mask;
        wr_data  = ld_we ? ld_data : head.data;
        vld_nxt  = vld;
        if (pop)
            vld_nxt = vld_nxt & ~(2'b01 << rp);
        if (push)
            vld_nxt = vld_nxt | (2'b01 << wp);
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < 2; i++)
            if (vld[i])
                busy_mask[fifo[i].dest] = 1'b1;
    end

    function automatic logic [BITS_ARRAY-1:0] rd_port(
        input logic [BITS_ADDR-1:0] a
    );
        logic [BITS_ARRAY-1:0] d;
        d = regs[a];
        if (wr_en && wr_addr == a)
            for (int l = 0; l < LANES; l++)
                if (wr_lanes[l])
                    d[l*BITS_DATA +: BITS_DATA] =
                        wr_data[l*BITS_DATA +: BITS_DATA];
        return d;
    endfunction

    always_comb begin
        rd_data_a = rd_port(rd_addr_a);
        rd_data_b = rd_port(rd_addr_b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld      <= '0;
            wp       <= 1'b0;
            rp       <= 1'b0;
            wb_count <= '0;
        end else begin
            vld <= vld_nxt;
            if (push) begin
                fifo[wp] <= '{dest: ex.dest, mask: ex.mask,
                              data: ex.result};
                wp       <= ~wp;
            end
            if (pop) begin
                rp       <= ~rp;
                wb_count <= wb_count + BITS_CNT'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REG_COUNT; r++)
                regs[r] <= '0;
        end else if (wr_en) begin
            for (int l = 0; l < LANES; l++)
                if (wr_lanes[l])
                    regs[wr_addr][l*BITS_DATA +: BITS_DATA] <=
                        wr_data[l*BITS_DATA +: BITS_DATA];
        end
    end
endmodule
